// File: rtl/gdu_pkg.sv
// Shared types and constants for the graphics display unit memory path.
package gdu_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StCmd,
        StRdData,
        StWrBurst
    } arb_state_t;

    localparam int unsigned MAX_BURST = 8;
    localparam logic        DISPLAY   = 1'b0;
    localparam logic        BLITTER   = 1'b1;

    // A burstcount of zero is treated as a single beat.
    function automatic logic [3:0] eff_burst(input logic [3:0] bc);
        return (bc == 4'd0) ? 4'd1 : bc;
    endfunction

endpackage

// File: rtl/avalon_master_arbiter.sv
// Two-port Avalon-MM arbiter: display fetcher has priority, blitter is protected from starvation
// by a consecutive-grant limit. One transaction at a time, IDLE bubble between grants.
module avalon_master_arbiter
    import gdu_pkg::*;
#(
    parameter int unsigned MAX_CONSEC = 4,
    parameter int unsigned ADDR_W     = 32
) (
    input  logic              clk,
    input  logic              reset,

    input  logic [ADDR_W-1:0] m0_address,
    input  logic [3:0]        m0_burstcount,
    input  logic [3:0]        m0_byteenable,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [31:0]       m0_writedata,
    output logic [31:0]       m0_readdata,
    output logic              m0_readdatavalid,
    output logic              m0_waitrequest,

    input  logic [ADDR_W-1:0] m1_address,
    input  logic [3:0]        m1_burstcount,
    input  logic [3:0]        m1_byteenable,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [31:0]       m1_writedata,
    output logic [31:0]       m1_readdata,
    output logic              m1_readdatavalid,
    output logic              m1_waitrequest,

    output logic [ADDR_W-1:0] s_address,
    output logic [3:0]        s_burstcount,
    output logic [3:0]        s_byteenable,
    output logic              s_read,
    output logic              s_write,
    output logic [31:0]       s_writedata,
    input  logic [31:0]       s_readdata,
    input  logic              s_readdatavalid,
    input  logic              s_waitrequest,
    input  logic [1:0]        s_response,
    input  logic              s_writeresponsevalid
);

    localparam int unsigned CW     = $clog2(MAX_CONSEC + 1);
    localparam int unsigned BEAT_W = $clog2(MAX_BURST) + 1;
    localparam logic [CW-1:0] MAX_C = CW'(MAX_CONSEC);

    arb_state_t        state;
    logic              grant;
    logic [CW-1:0]     consec;
    logic [BEAT_W-1:0] beats;
    logic [3:0]        burst_len;

    logic              req0, req1;
    logic              g_read, g_write, g_wait;
    logic              unused_inputs;

    assign req0          = m0_read | m0_write;
    assign req1          = m1_read | m1_write;
    assign unused_inputs = ^{s_response, s_writeresponsevalid};

    always_comb begin
        g_read       = (grant == BLITTER) ? m1_read  : m0_read;
        g_write      = (grant == BLITTER) ? m1_write : m0_write;
        s_address    = (grant == BLITTER) ? m1_address    : m0_address;
        s_byteenable = (grant == BLITTER) ? m1_byteenable : m0_byteenable;
        s_writedata  = (grant == BLITTER) ? m1_writedata  : m0_writedata;
        s_burstcount = burst_len;

        // Read wins over a simultaneous write; only CMD may issue a read.
        s_read  = (state == StCmd) & g_read;
        s_write = ((state == StCmd) & g_write & ~g_read) | ((state == StWrBurst) & g_write);
        g_wait  = ((state == StCmd) || (state == StWrBurst)) ? s_waitrequest : 1'b1;

        m0_waitrequest   = (grant == DISPLAY) ? g_wait : 1'b1;
        m1_waitrequest   = (grant == BLITTER) ? g_wait : 1'b1;
        m0_readdata      = s_readdata;
        m1_readdata      = s_readdata;
        m0_readdatavalid = (state == StRdData) & (grant == DISPLAY) & s_readdatavalid;
        m1_readdatavalid = (state == StRdData) & (grant == BLITTER) & s_readdatavalid;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= StIdle;
            grant     <= DISPLAY;
            consec    <= '0;
            beats     <= '0;
            burst_len <= 4'd1;
        end else begin
            if (!req1) begin
                consec <= '0;
            end
            unique case (state)
                StIdle: begin
                    if (req0 && ((consec < MAX_C) || !req1)) begin
                        grant     <= DISPLAY;
                        burst_len <= eff_burst(m0_burstcount);
                        beats     <= '0;
                        state     <= StCmd;
                        if (req1) begin
                            consec <= consec + 1'b1;
                        end
                    end else if (req1) begin
                        grant     <= BLITTER;
                        burst_len <= eff_burst(m1_burstcount);
                        beats     <= '0;
                        consec    <= '0;
                        state     <= StCmd;
                    end
                end
                StCmd: begin
                    if (g_read) begin
                        if (!s_waitrequest) begin
                            state <= StRdData;
                        end
                    end else if (g_write) begin
                        if (!s_waitrequest) begin
                            beats <= BEAT_W'(1);
                            state <= (burst_len == 4'd1) ? StIdle : StWrBurst;
                        end
                    end else begin
                        // Requester withdrew before issuing anything.
                        state <= StIdle;
                    end
                end
                StRdData: begin
                    if (s_readdatavalid) begin
                        beats <= beats + BEAT_W'(1);
                        if (beats + BEAT_W'(1) == burst_len) begin
                            state <= StIdle;
                        end
                    end
                end
                StWrBurst: begin
                    if (g_write && !s_waitrequest) begin
                        beats <= beats + BEAT_W'(1);
                        if (beats + BEAT_W'(1) == burst_len) begin
                            state <= StIdle;
                        end
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_avalon_master_arbiter.sv
// Scoreboard bench for avalon_master_arbiter: directed transactions, a downstream slave model
// and a negedge monitor that pops expected commands, write beats and read beats.
module tb_avalon_master_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] m0_address, m1_address, m0_writedata, m1_writedata;
    logic [3:0]  m0_burstcount, m1_burstcount, m0_byteenable, m1_byteenable;
    logic        m0_read, m0_write, m1_read, m1_write;
    logic [31:0] m0_readdata, m1_readdata;
    logic        m0_readdatavalid, m1_readdatavalid, m0_waitrequest, m1_waitrequest;
    logic [31:0] s_address, s_writedata, s_readdata;
    logic [3:0]  s_burstcount, s_byteenable;
    logic        s_read, s_write, s_readdatavalid, s_waitrequest;
    logic [1:0]  s_response;
    logic        s_writeresponsevalid;

    avalon_master_arbiter #(.MAX_CONSEC(4), .ADDR_W(32)) dut (
        .clk(clk), .reset(reset),
        .m0_address(m0_address), .m0_burstcount(m0_burstcount), .m0_byteenable(m0_byteenable),
        .m0_read(m0_read), .m0_write(m0_write), .m0_writedata(m0_writedata),
        .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
        .m0_waitrequest(m0_waitrequest),
        .m1_address(m1_address), .m1_burstcount(m1_burstcount), .m1_byteenable(m1_byteenable),
        .m1_read(m1_read), .m1_write(m1_write), .m1_writedata(m1_writedata),
        .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
        .m1_waitrequest(m1_waitrequest),
        .s_address(s_address), .s_burstcount(s_burstcount), .s_byteenable(s_byteenable),
        .s_read(s_read), .s_write(s_write), .s_writedata(s_writedata),
        .s_readdata(s_readdata), .s_readdatavalid(s_readdatavalid),
        .s_waitrequest(s_waitrequest), .s_response(s_response),
        .s_writeresponsevalid(s_writeresponsevalid)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          port;
        logic [31:0] a;
        logic [31:0] b;
    } exp_t;

    exp_t q_cmd[$];
    exp_t q_wr[$];
    exp_t q_rd[$];

    int errors = 0, checks = 0, cyc = 0;
    int sread_cycles = 0, rdv_cnt = 0, wr_cnt = 0, m0_low_cnt = 0, stall_cnt = 0;
    int cmd_cycle[2], last_rdv_cycle[2];
    bit slave_busy = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: event not seen within bound (got none, expected one)", name);
    endtask

    function automatic logic [31:0] rdata(input logic [31:0] addr, input int i);
        return addr ^ (32'hA5A5_0000 + 32'(i));
    endfunction

    task automatic push_read(input int p, input logic [31:0] a, input int bc);
        q_cmd.push_back('{port: p, a: a, b: 32'(bc)});
        for (int i = 0; i < bc; i++) q_rd.push_back('{port: p, a: a, b: rdata(a, i)});
    endtask

    // Monitor: every DUT output event pops the next expected entry.
    int   mp;
    exp_t me;
    always @(negedge clk) begin
        if (!reset) begin
            if (s_read) sread_cycles++;
            if (!m0_waitrequest) m0_low_cnt++;
            if (s_write && m1_waitrequest) stall_cnt++;
            if (s_read && !s_waitrequest) begin
                mp = m0_waitrequest ? 1 : 0;
                chk("cmd_one_port", 64'(m0_waitrequest ^ m1_waitrequest), 64'd1);
                cmd_cycle[mp] = cyc;
                if (q_cmd.size() == 0) fail("unexpected_read_cmd");
                else begin
                    me = q_cmd.pop_front();
                    chk("cmd_port", 64'(mp), 64'(me.port));
                    chk("cmd_addr", 64'(s_address), 64'(me.a));
                    chk("cmd_burst", 64'(s_burstcount), 64'(me.b));
                end
            end
            if (s_write && !s_waitrequest) begin
                mp = m0_waitrequest ? 1 : 0;
                wr_cnt++;
                if (q_wr.size() == 0) fail("unexpected_write_beat");
                else begin
                    me = q_wr.pop_front();
                    chk("wr_port", 64'(mp), 64'(me.port));
                    chk("wr_addr", 64'(s_address), 64'(me.a));
                    chk("wr_data", 64'(s_writedata), 64'(me.b));
                end
            end
            if (m0_readdatavalid && m1_readdatavalid) fail("rdv_single_port");
            else if (m0_readdatavalid || m1_readdatavalid) begin
                mp = m1_readdatavalid ? 1 : 0;
                rdv_cnt++;
                last_rdv_cycle[mp] = cyc;
                if (q_rd.size() == 0) fail("unexpected_readdatavalid");
                else begin
                    me = q_rd.pop_front();
                    chk("rd_port", 64'(mp), 64'(me.port));
                    chk("rd_data", 64'(mp ? m1_readdata : m0_readdata), 64'(me.b));
                end
            end
        end
    end

    // Downstream slave: returns burstcount beats starting the cycle after command acceptance.
    logic [31:0] slv_addr;
    int          slv_n;
    initial begin
        s_readdatavalid = 1'b0;
        s_readdata      = 32'h0;
        forever begin
            @(negedge clk);
            if (!reset && s_read && !s_waitrequest) begin
                slv_addr   = s_address;
                slv_n      = int'(s_burstcount);
                slave_busy = 1'b1;
                @(posedge clk); #1;
                for (int i = 0; i < slv_n; i++) begin
                    s_readdatavalid = 1'b1;
                    s_readdata      = rdata(slv_addr, i);
                    @(posedge clk); #1;
                end
                s_readdatavalid = 1'b0;
                s_readdata      = 32'hDEAD_BEEF;
                slave_busy      = 1'b0;
            end
        end
    end

    task automatic set_req(input int p, input logic rd, input logic wr, input logic [31:0] a,
                           input logic [3:0] bc, input logic [31:0] d);
        if (p == 0) begin
            m0_read = rd; m0_write = wr; m0_address = a; m0_burstcount = bc; m0_writedata = d;
        end else begin
            m1_read = rd; m1_write = wr; m1_address = a; m1_burstcount = bc; m1_writedata = d;
        end
    endtask

    task automatic wait_accept(input int p, input string name);
        bit ok = 1'b0;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (!(p == 0 ? m0_waitrequest : m1_waitrequest)) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail({name, "_accept"});
        @(posedge clk); #1;
    endtask

    task automatic port_read(input int p, input logic [31:0] a, input logic [3:0] bc,
                             input bit keep);
        set_req(p, 1'b1, 1'b0, a, bc, 32'h0);
        wait_accept(p, "read");
        if (!keep) set_req(p, 1'b0, 1'b0, a, bc, 32'h0);
    endtask

    task automatic port_write(input int p, input logic [31:0] a, input int n,
                              input logic [31:0] d0);
        for (int i = 0; i < n; i++) begin
            set_req(p, 1'b0, 1'b1, a, 4'(n), d0 + 32'(i));
            wait_accept(p, "write");
        end
        set_req(p, 1'b0, 1'b0, a, 4'(n), 32'h0);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((q_cmd.size() != 0 || q_wr.size() != 0 || q_rd.size() != 0 || slave_busy)
               && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_pending"}, 64'(q_cmd.size() + q_wr.size() + q_rd.size()), 64'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int base, req_cyc;
    bit hit;
    initial begin
        reset = 1'b1;
        s_waitrequest = 1'b0;
        s_response = 2'b00;
        s_writeresponsevalid = 1'b0;
        m0_byteenable = 4'hF;
        m1_byteenable = 4'hF;
        set_req(0, 1'b1, 1'b0, 32'h0, 4'd1, 32'h0);
        set_req(1, 1'b0, 1'b0, 32'h0, 4'd1, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_s_read", 64'(s_read), 64'd0);
        chk("rst_s_write", 64'(s_write), 64'd0);
        chk("rst_m0_wait", 64'(m0_waitrequest), 64'd1);
        chk("rst_m1_wait", 64'(m1_waitrequest), 64'd1);
        chk("rst_rdv", 64'({m0_readdatavalid, m1_readdatavalid}), 64'd0);
        set_req(0, 1'b0, 1'b0, 32'h0, 4'd1, 32'h0);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("idle_wait", 64'({m0_waitrequest, m1_waitrequest}), 64'd3);

        // Blitter 8-beat read; command for one cycle, one-cycle grant latency.
        push_read(1, 32'h1000, 8);
        base = sread_cycles;
        req_cyc = cyc;
        port_read(1, 32'h1000, 4'd8, 1'b0);
        chk("a_grant_latency", 64'(cmd_cycle[1] - req_cyc), 64'd1);
        drain("a");
        chk("a_sread_cycles", 64'(sread_cycles - base), 64'd1);
        chk("a_idle", 64'({m0_waitrequest, m1_waitrequest}), 64'd3);

        // Simultaneous reads: display first, blitter after last beat plus one IDLE cycle.
        push_read(0, 32'h2000, 2);
        push_read(1, 32'h3000, 3);
        fork
            port_read(0, 32'h2000, 4'd2, 1'b0);
            port_read(1, 32'h3000, 4'd3, 1'b0);
        join
        drain("b");
        chk("b_gap", 64'(cmd_cycle[1] - last_rdv_cycle[0]), 64'd2);

        // Continuous display traffic: blitter gets in after exactly 4 display grants.
        for (int i = 0; i < 4; i++) push_read(0, 32'h7000 + 32'(16 * i), 1);
        push_read(1, 32'h7100, 1);
        for (int i = 4; i < 6; i++) push_read(0, 32'h7000 + 32'(16 * i), 1);
        fork
            begin
                for (int i = 0; i < 6; i++) port_read(0, 32'h7000 + 32'(16 * i), 4'd1, i < 5);
            end
            port_read(1, 32'h7100, 4'd1, 1'b0);
        join
        drain("c");

        // Blitter 4-beat write, beat 2 stalled for 3 cycles.
        for (int i = 0; i < 4; i++) q_wr.push_back('{port: 1, a: 32'h8000, b: 32'hC0DE_0000 + 32'(i)});
        base = wr_cnt;
        stall_cnt = 0;
        m0_low_cnt = 0;
        fork
            port_write(1, 32'h8000, 4, 32'hC0DE_0000);
            begin
                hit = 1'b0;
                for (int n = 0; n < 100; n++) begin
                    @(negedge clk); #1;
                    if (wr_cnt == base + 1) begin
                        hit = 1'b1;
                        break;
                    end
                end
                if (!hit) fail("d_first_beat");
                @(posedge clk); #1;
                s_waitrequest = 1'b1;
                repeat (3) @(posedge clk);
                #1;
                s_waitrequest = 1'b0;
            end
        join
        drain("d");
        chk("d_beats", 64'(wr_cnt - base), 64'd4);
        chk("d_stall_cycles", 64'(stall_cnt), 64'd3);
        chk("d_m0_wait_low", 64'(m0_low_cnt), 64'd0);

        // burstcount 0 behaves as a single beat.
        push_read(0, 32'h4000, 1);
        port_read(0, 32'h4000, 4'd0, 1'b0);
        drain("e");
        chk("e_idle", 64'({m0_waitrequest, m1_waitrequest}), 64'd3);

        // Reset after 3 of 8 beats; the rest must be discarded.
        push_read(0, 32'h5000, 3);
        q_cmd.pop_back();
        q_cmd.push_back('{port: 0, a: 32'h5000, b: 32'd8});
        base = rdv_cnt;
        port_read(0, 32'h5000, 4'd8, 1'b0);
        hit = 1'b0;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk); #1;
            if (rdv_cnt == base + 3) begin
                hit = 1'b1;
                break;
            end
        end
        if (!hit) fail("r_three_beats");
        reset = 1'b1;
        #1;
        chk("r_s_read", 64'(s_read), 64'd0);
        chk("r_s_write", 64'(s_write), 64'd0);
        chk("r_wait", 64'({m0_waitrequest, m1_waitrequest}), 64'd3);
        chk("r_rdv", 64'({m0_readdatavalid, m1_readdatavalid}), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        drain("r_stale");
        chk("r_rdv_total", 64'(rdv_cnt - base), 64'd3);
        push_read(0, 32'h6000, 2);
        port_read(0, 32'h6000, 4'd2, 1'b0);
        drain("r_after");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/avalon_master_arbiter.md
AVALON_MASTER_ARBITER -- requirements
Module: avalon_master_arbiter

Interface
REQ-001 Parameter MAX_CONSEC, default 4, is the maximum number of consecutive port-0 grants allowed while port 1 is waiting.
REQ-002 Parameter ADDR_W, default 32, is the address width on all ports.
REQ-003 clk  in  1  sole clock.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 mN_address (N=0,1)  in  ADDR_W  requester address; port 0 is the display scanline fetcher (high priority), port 1 is the sprite blitter.
REQ-006 mN_burstcount  in  4  requester burst length, 1..8.
REQ-007 mN_byteenable  in  4  requester byte enables.
REQ-008 mN_read  in  1  requester read command.
REQ-009 mN_write  in  1  requester write command.
REQ-010 mN_writedata  in  32  requester write data.
REQ-011 mN_readdata  out  32  read data returned to the requester.
REQ-012 mN_readdatavalid  out  1  read data valid for the requester.
REQ-013 mN_waitrequest  out  1  stall signal to the requester.
REQ-014 s_address, s_burstcount, s_byteenable, s_read, s_write, s_writedata  out  downstream Avalon master command, with widths as above.
REQ-015 s_readdata  in  32  downstream read data.
REQ-016 s_readdatavalid  in  1  downstream read data valid.
REQ-017 s_waitrequest  in  1  downstream stall.
REQ-018 s_response  in  2  downstream response, ignored.
REQ-019 s_writeresponsevalid  in  1  downstream write response valid, ignored.

Function
REQ-020 State machine states: IDLE, CMD, RD_DATA, WR_BURST.
REQ-021 IDLE: port 0 requesting (read|write) and consec<MAX_CONSEC, or port 1 idle -> grant=0; otherwise, if port 1 is requesting -> grant=1; the selected state is CMD; with no request, stay in IDLE.
REQ-022 The consec counter increments on each port-0 grant made while port 1 is requesting, clears on any port-1 grant, and clears when port 1 is not requesting.
REQ-023 In IDLE, s_read=s_write=0 and both mN_waitrequest=1.
REQ-024 In CMD/RD_DATA/WR_BURST, the s_* command outputs are combinationally muxed from the granted port.
REQ-025 In those states the granted port's waitrequest equals s_waitrequest, and the non-granted port's waitrequest is 1.
REQ-026 The burstcount is latched at grant; a value of 0 is treated as 1.
REQ-027 The beat counter (4 bits) is cleared at grant.
REQ-028 CMD with read & !s_waitrequest -> RD_DATA; from RD_DATA onward, s_read=0 and the granted waitrequest is 1.
REQ-029 RD_DATA: each s_readdatavalid is routed to the granted port's readdatavalid/readdata and increments beats; when beats+1==burstcount -> IDLE.
REQ-030 CMD with write & !s_waitrequest counts beat 1; with burstcount==1 -> IDLE, else -> WR_BURST.
REQ-031 WR_BURST: each accepted beat (write & !s_waitrequest) increments beats; when the final beat is accepted -> IDLE.
REQ-032 In WR_BURST, a write low on the granted port holds the state, with no timeout.
REQ-033 A one-cycle IDLE bubble separates consecutive grants.
REQ-034 Grant decision to the first s_read/s_write assertion is 1 cycle.
REQ-035 mN_readdata always mirrors s_readdata, while mN_readdatavalid is asserted only for the owning port in RD_DATA.
REQ-036 s_readdatavalid arriving outside RD_DATA is discarded, and no port sees it.
REQ-037 If a requester asserts read and write together, read wins.
REQ-038 If both ports request in the same IDLE cycle, REQ-021 decides the grant.

Reset
REQ-039 Reset asynchronously forces state=IDLE, grant=0, consec=0, beats=0, and latched burstcount=1.
REQ-040 Outputs during reset: s_read=0, s_write=0, mN_waitrequest=1, mN_readdatavalid=0.
REQ-041 Reset mid-burst abandons the outstanding transaction, and late readdatavalid beats are discarded per REQ-036.

Structure
REQ-042 A shared package gdu_pkg holds the arb_state_t enum, the MAX_BURST=8 constant and the port index constants DISPLAY=0, BLITTER=1.
REQ-043 The command/response mux and the FSM live in a single module, with no sub-module.

Verification
REQ-044 Port-1 read at 0x1000, burstcount 8 -> s_read held for 1 cycle after grant, then 8 readdatavalid beats reach port 1 only, then IDLE.
REQ-045 Both ports assert read in the same cycle -> port 0 is granted first; port 1 is granted after port 0's last data beat plus 1 IDLE cycle.
REQ-046 Port 0 requests continuously with MAX_CONSEC=4 while port 1 waits -> port 1 is granted after exactly 4 port-0 transactions.
REQ-047 Port-1 write burst of 4 with s_waitrequest high for 3 cycles on beat 2 -> exactly 4 beats are accepted, and port 0 waitrequest stays 1 throughout.
REQ-048 Reset asserted after 3 of 8 read beats -> immediate IDLE with outputs per REQ-040; the remaining 5 beats are dropped and the next port-0 read completes correctly.
REQ-049 burstcount=0 read -> handled as a single beat and returns to IDLE after one readdatavalid.
